// File: rtl/calendar_date_counter_if.sv
// Key/select inputs and date outputs of the calendar date counter.
//   day_tick   : midnight pulse from the time-of-day counter
//   up, select : per-field key levels and field-select one-hot ([0]=day, [1]=month, [2]=year)
//   day, month, year_ofs, leap       : current date and leap flag
//   set_active, new_day, year_wrap   : status outputs
// master drives the inputs and observes the date; slave is the counter side.
interface calendar_date_counter_if;
    logic       day_tick;
    logic [2:0] up;
    logic [2:0] select;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year_ofs;
    logic       leap;
    logic       set_active;
    logic       new_day;
    logic       year_wrap;

    modport master (
        output day_tick, up, select,
        input  day, month, year_ofs, leap, set_active, new_day, year_wrap
    );

    modport slave (
        input  day_tick, up, select,
        output day, month, year_ofs, leap, set_active, new_day, year_wrap
    );
endinterface

// File: rtl/calendar_date_counter.sv
// Calendar date counter: holds day/month/year offset from 2000, advances on the
// daily tick, and lets the user step the selected field with the up key.
// Ticks that arrive while a field is being edited are held (collapsed to one)
// and applied when select returns to 000.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : calendar_date_counter_if.slave (inputs day_tick/up/select,
//                outputs day/month/year_ofs/leap/set_active/new_day/year_wrap)
module calendar_date_counter #(
    parameter int unsigned DAY_RESET   = 1,
    parameter int unsigned MONTH_RESET = 1,
    parameter int unsigned YEAR_RESET  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    calendar_date_counter_if.slave   bus
);

    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned YEAR_W  = 7;
    localparam int unsigned KEY_W   = 3;

    localparam int unsigned F_DAY   = 0;
    localparam int unsigned F_MONTH = 1;
    localparam int unsigned F_YEAR  = 2;

    logic [DAY_W-1:0]   day_q,   day_n;
    logic [MONTH_W-1:0] month_q, month_n;
    logic [YEAR_W-1:0]  year_q,  year_n;
    logic [KEY_W-1:0]   up_d;
    logic               tick_pending_q, tick_pending_n;
    logic               set_active_q;
    logic               new_day_q, new_day_n;
    logic               year_wrap_q, year_wrap_n;

    logic               leap_c;
    logic               set_mode_c;
    logic [KEY_W-1:0]   up_rise_c;
    logic [KEY_W-1:0]   hit_c;
    logic [DAY_W-1:0]   dim_cur_c;
    logic [DAY_W-1:0]   dim_new;

    // Days in a month for a given leap flag
    function automatic logic [DAY_W-1:0] dim_of(input logic [MONTH_W-1:0] m, input logic lp);
        logic [DAY_W-1:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = lp ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // Year offsets divisible by 4 are leap (2000 included, range ends at 2099)
    assign leap_c     = (year_q[1:0] == 2'b00);
    assign set_mode_c = |bus.select;
    assign up_rise_c  = bus.up & ~up_d;
    assign hit_c      = bus.select & up_rise_c;
    assign dim_cur_c  = dim_of(month_q, leap_c);

    // Next-state: set-mode edits, tick deferral and daily advance
    always_comb begin
        day_n          = day_q;
        month_n        = month_q;
        year_n         = year_q;
        tick_pending_n = tick_pending_q;
        new_day_n      = 1'b0;
        year_wrap_n    = 1'b0;
        dim_new        = dim_cur_c;

        if (set_mode_c) begin
            if (bus.day_tick) begin
                tick_pending_n = 1'b1;
            end
            if (hit_c[F_YEAR]) begin
                year_n = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                // Feb 29 does not survive a move to a non-leap year
                if (month_q == 4'd2 && day_q == 5'd29 && year_n[1:0] != 2'b00) begin
                    day_n = 5'd28;
                end
            end else if (hit_c[F_MONTH]) begin
                month_n = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
                dim_new = dim_of(month_n, leap_c);
                if (day_q > dim_new) begin
                    day_n = dim_new;
                end
            end else if (hit_c[F_DAY]) begin
                day_n = (day_q == dim_cur_c) ? 5'd1 : day_q + 5'd1;
            end
        end else if (bus.day_tick || tick_pending_q) begin
            // A live tick and a held tick together still advance only one day
            tick_pending_n = 1'b0;
            new_day_n      = 1'b1;
            if (day_q < dim_cur_c) begin
                day_n = day_q + 5'd1;
            end else begin
                day_n = 5'd1;
                if (month_q < 4'd12) begin
                    month_n = month_q + 4'd1;
                end else begin
                    month_n = 4'd1;
                    if (year_q == 7'd99) begin
                        year_n      = 7'd0;
                        year_wrap_n = 1'b1;
                    end else begin
                        year_n = year_q + 7'd1;
                    end
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q          <= DAY_W'(DAY_RESET);
            month_q        <= MONTH_W'(MONTH_RESET);
            year_q         <= YEAR_W'(YEAR_RESET);
            up_d           <= '0;
            tick_pending_q <= 1'b0;
            set_active_q   <= 1'b0;
            new_day_q      <= 1'b0;
            year_wrap_q    <= 1'b0;
        end else begin
            day_q          <= day_n;
            month_q        <= month_n;
            year_q         <= year_n;
            up_d           <= bus.up;
            tick_pending_q <= tick_pending_n;
            set_active_q   <= set_mode_c;
            new_day_q      <= new_day_n;
            year_wrap_q    <= year_wrap_n;
        end
    end

    assign bus.day        = day_q;
    assign bus.month      = month_q;
    assign bus.year_ofs   = year_q;
    assign bus.leap       = leap_c;
    assign bus.set_active = set_active_q;
    assign bus.new_day    = new_day_q;
    assign bus.year_wrap  = year_wrap_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter: inputs driven and outputs sampled
// on the falling clock edge.
module tb_calendar_date_counter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    calendar_date_counter_if bus ();

    calendar_date_counter #(
        .DAY_RESET   (1),
        .MONTH_RESET (1),
        .YEAR_RESET  (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int field_val(input int f);
        case (f)
            0:       return int'(bus.day);
            1:       return int'(bus.month);
            default: return int'(bus.year_ofs);
        endcase
    endfunction

    // One rising edge on up[f]: high for one cycle, low for one cycle
    task automatic pulse(input int f);
        bus.up = 3'(1 << f);
        @(negedge clk);
        bus.up = 3'b000;
        @(negedge clk);
    endtask

    // Step field f with the up key until it reads target (bounded)
    task automatic set_field(input int f, input int target);
        bit done;
        done = 1'b0;
        bus.select = 3'(1 << f);
        for (int i = 0; i < 128 && !done; i++) begin
            if (field_val(f) == target) done = 1'b1;
            else pulse(f);
        end
        check($sformatf("set_field%0d", f), field_val(f), target);
    endtask

    task automatic set_date(input int y, input int m, input int d);
        set_field(2, y);
        set_field(1, m);
        set_field(0, d);
        bus.select = 3'b000;
        @(negedge clk);
    endtask

    task automatic tick();
        bus.day_tick = 1'b1;
        @(negedge clk);
        bus.day_tick = 1'b0;
    endtask

    task automatic check_date(input string tag, input int y, input int m, input int d);
        check({tag, "_year"},  int'(bus.year_ofs), y);
        check({tag, "_month"}, int'(bus.month),    m);
        check({tag, "_day"},   int'(bus.day),      d);
    endtask

    initial begin
        int nd_cnt;
        int wrap_cnt;
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.day_tick = 1'b0;
        bus.up       = 3'b000;
        bus.select   = 3'b000;
        repeat (2) @(negedge clk);

        // Reset state
        check_date("rst", 0, 1, 1);
        check("rst_leap",       int'(bus.leap),       1);
        check("rst_set_active", int'(bus.set_active), 0);
        check("rst_new_day",    int'(bus.new_day),    0);
        check("rst_year_wrap",  int'(bus.year_wrap),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // 31 back-to-back ticks through January
        nd_cnt   = 0;
        wrap_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            bus.day_tick = 1'b1;
            @(negedge clk);
            if (bus.new_day)   nd_cnt++;
            if (bus.year_wrap) wrap_cnt++;
        end
        bus.day_tick = 1'b0;
        @(negedge clk);
        check_date("jan31", 0, 2, 1);
        check("jan31_new_day_cnt", nd_cnt, 31);
        check("jan31_wrap_cnt",    wrap_cnt, 0);
        check("jan31_new_day_off", int'(bus.new_day), 0);

        // Non-leap Feb 28 -> Mar 1
        set_date(23, 2, 28);
        check("y23_leap", int'(bus.leap), 0);
        tick();
        check_date("feb28_23", 23, 3, 1);
        check("feb28_23_new_day", int'(bus.new_day), 1);

        // Leap Feb 28 -> Feb 29
        set_date(24, 2, 28);
        tick();
        check_date("feb28_24", 24, 2, 29);
        check("feb28_24_leap", int'(bus.leap), 1);

        // Century wrap
        set_date(99, 12, 31);
        check("y99_leap", int'(bus.leap), 0);
        tick();
        check_date("wrap", 0, 1, 1);
        check("wrap_pulse", int'(bus.year_wrap), 1);
        check("wrap_leap",  int'(bus.leap),      1);
        @(negedge clk);
        check("wrap_pulse_off", int'(bus.year_wrap), 0);
        check("wrap_new_day_off", int'(bus.new_day), 0);

        // Held key gives one increment: Apr 30 -> 1, month unchanged
        set_date(0, 4, 30);
        bus.select = 3'b001;
        bus.up     = 3'b001;
        repeat (10) @(negedge clk);
        bus.up = 3'b000;
        @(negedge clk);
        check("hold_day",   int'(bus.day),   1);
        check("hold_month", int'(bus.month), 4);
        check("hold_set_active", int'(bus.set_active), 1);
        for (int i = 0; i < 5; i++) pulse(0);
        check("five_pulses_day", int'(bus.day), 6);
        bus.select = 3'b000;
        @(negedge clk);
        check("set_active_off", int'(bus.set_active), 0);

        // Month clamp into leap Feb, then year clamp out of it
        set_date(24, 1, 31);
        bus.select = 3'b010;
        pulse(1);
        check_date("mclamp", 24, 2, 29);
        bus.select = 3'b100;
        pulse(2);
        check_date("yclamp", 25, 2, 28);
        bus.select = 3'b000;
        @(negedge clk);

        // Up keys ignored in run mode
        pulse(0);
        check("run_up_ignored", int'(bus.day), 28);

        // Ticks deferred during set mode collapse into one advance
        set_date(24, 5, 10);
        bus.select = 3'b001;
        @(negedge clk);
        nd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.new_day) nd_cnt++;
            @(negedge clk);
            if (bus.new_day) nd_cnt++;
        end
        check_date("held", 24, 5, 10);
        check("held_new_day_cnt", nd_cnt, 0);
        bus.select = 3'b000;
        @(negedge clk);
        check_date("release", 24, 5, 11);
        check("release_new_day", int'(bus.new_day), 1);
        @(negedge clk);
        check("release_once_day", int'(bus.day),     11);
        check("release_new_day_off", int'(bus.new_day), 0);

        // Reset discards a pending tick
        bus.select = 3'b001;
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_date("rst_pend", 0, 1, 1);
        @(negedge clk);
        bus.select = 3'b000;
        rst_n      = 1'b1;
        nd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.new_day) nd_cnt++;
        end
        check_date("post_rst", 0, 1, 1);
        check("post_rst_new_day_cnt", nd_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Downstream consumer of the calendar key demux: takes its per-field `up[2:0]` key levels and `select[2:0]` field-select one-hot.
- Holds the current date (day, month, 2-digit year offset from 2000) and advances it on a once-per-day tick from the time-of-day counter.
- Lets the user set each field with the up key while that field is selected.
- Feeds the display/driver stage and the weekday logic.

Parameters:
- DAY_RESET, 1, day value loaded at reset (1..28).
- MONTH_RESET, 1, month value loaded at reset (1..12).
- YEAR_RESET, 0, year offset loaded at reset (0..99, year = 2000 + offset).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- day_tick  input  1  one-cycle pulse at midnight rollover; advances date by one day
- up  input  3  key levels from demux: [0]=day, [1]=month, [2]=year
- select  input  3  field select from demux, same bit mapping; 000 = run mode
- day  output  5  current day, 1..31
- month  output  4  current month, 1..12
- year_ofs  output  7  current year offset, 0..99
- leap  output  1  1 when year_ofs is a leap year (year_ofs % 4 == 0; 2000 is leap)
- set_active  output  1  registered OR of select
- new_day  output  1  one-cycle pulse when a tick-driven advance is applied
- year_wrap  output  1  one-cycle pulse when a tick-driven advance takes 2099-12-31 to 2000-01-01

Behaviour:
- Reset (async, rst_n=0):
  - day=DAY_RESET, month=MONTH_RESET, year_ofs=YEAR_RESET.
  - leap derived from YEAR_RESET.
  - set_active=0, new_day=0, year_wrap=0.
  - Internal up_d=000, tick_pending=0.
  - Reset mid-operation discards any pending tick.
- Edge detect: up_d <= up every cycle. up_rise = up & ~up_d. Each rising edge gives exactly one increment; holding the key gives no auto-repeat.
- Days-in-month (dim): 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; Feb is 29 if leap, else 28.
- Set mode (select != 000):
  - Increment only the field whose select bit is set and whose up_rise bit is set.
  - If several bits are set (illegal from demux), priority is year > month > day.
  - Day: day == dim -> 1, else day+1. No carry into month.
  - Month: 12 -> 1, else +1. Then clamp: if day > dim(new month, current year), day = dim.
  - Year: 99 -> 0, else +1. Then clamp: if month==2 and day==29 and the new year is not leap, day = 28.
  - Field updates take 1 cycle: outputs change on the clock edge after the up_rise cycle.
- Tick handling:
  - day_tick while select != 000: set tick_pending=1; no date change.
  - Multiple ticks while pending collapse into one pending tick.
  - Run mode (select == 000) with day_tick or tick_pending set: advance by one day and clear tick_pending. A tick and a pending flag together advance by only one day.
  - Advance rule: if day < dim, day+1. Else day=1, and if month < 12 then month+1; otherwise month=1 and year_ofs = (year_ofs==99) ? 0 : year_ofs+1.
  - new_day=1 for the cycle after the advance. year_wrap=1 only for the 99->0 carry.
- up_rise bits while select == 000 are ignored.
- On the cycle select returns to 000, the pending advance applies. up_rise in that cycle is ignored.
- set_active = |select, registered, one-cycle latency.
- leap updates combinationally from year_ofs, i.e. in the same cycle as the year_ofs register.
- Field arithmetic is unsigned. Illegal stored values cannot occur; the clamps guarantee 1 <= day <= dim.

Test Plan:
- Reset with defaults, then 31 day_ticks -> day=1, month=2, year_ofs=0, new_day pulsed 31 times, year_wrap=0.
- Date 2023-02-28 (year_ofs=23), day_tick -> 2023-03-01. Date 2024-02-28, day_tick -> 2024-02-29, leap=1.
- Date 2099-12-31, day_tick -> day=1, month=1, year_ofs=0, year_wrap=1 for one cycle, leap=1.
- select=001, hold up[0] high for 10 cycles from day=30 in April -> exactly one increment, day=1, month unchanged. Five separate pulses from day=1 -> day=6.
- Date 2024-01-31, select=010, one up[1] rise -> month=2, day=29. Then select=100, one up[2] rise -> year_ofs=25, day=28.
- select=001 held, three day_ticks at 2024-05-10 -> date unchanged, new_day=0. Drop select to 000 -> next edge date=2024-05-11, new_day one pulse. Assert rst_n=0 with a tick pending -> date=reset values, no advance after release.
